fp_add_sched: RTL and testbench
===============================

// Module: fp_add_sched
// PURPOSE
//  Shares one single-precision FP add/sub datapath (align, add, normalize, round) among NUM_REQ requesters.
//  Arbitrates round-robin, holds the winner's operands, counts the datapath latency and captures the result with flags.
//  Returns the result with the requester ID over a valid/ready response port.
//  Sits between the requesting units and the adder core.
// PARAMETERS
//  NUM_REQ      4   number of requesters (>=2)
//  ADD_LATENCY  3   clock edges from operands presented to result valid on add_* (>=1)
//  ID_W         2   requester ID width, $clog2(NUM_REQ)
// PORTS
//  clk           in   1           single clock, rising edge
//  rst_n         in   1           asynchronous, active-low reset
//  req_valid     in   NUM_REQ     per-requester operation valid
//  req_ready     out  NUM_REQ     per-requester accept (one-hot or zero)
//  req_a         in   NUM_REQ*32  operand A, requester i at [32i+31:32i]
//  req_b         in   NUM_REQ*32  operand B
//  req_sub       in   NUM_REQ     1 = A-B, 0 = A+B
//  add_a, add_b  out  32          operands to adder core
//  add_sub       out  1           op to adder core
//  add_start     out  1           one-cycle pulse, first cycle operands are valid
//  add_result    in   32          core result
//  add_overflow  in   1           core overflow flag
//  add_inexact   in   1           core inexact flag
//  rsp_valid     out  1           response valid
//  rsp_ready     in   1           response accept
//  rsp_id        out  ID_W        ID of the served requester
//  rsp_result    out  32          captured result
//  rsp_overflow  out  1           captured overflow
//  rsp_inexact   out  1           captured inexact
//  flag_clr      in   1           clear sticky flags (FLAG_STICKY_EN only)
//  flag_ovf      out  1           sticky overflow (FLAG_STICKY_EN only)
//  flag_inx      out  1           sticky inexact (FLAG_STICKY_EN only)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; counter 0. Reset mid-operation aborts; the op is lost.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: grant g = first asserted req_valid at or after the pointer, wrapping modulo NUM_REQ.
//   req_ready[g] = 1 combinationally. All req_ready are 0 outside IDLE.
//   On accept: latch a/b/sub/ID, set pointer = (g+1) mod NUM_REQ, cnt = 0, go BUSY.
//  BUSY: add_a/b/sub driven from the latched registers, stable for the whole state.
//   add_start = 1 only while cnt == 0. cnt increments each cycle.
//   When cnt == ADD_LATENCY-1: capture add_result/flags into rsp_* regs at that edge, go RESP.
//  RESP: rsp_valid = 1 and rsp_* held stable until rsp_ready. On handshake go IDLE, rsp_valid = 0 next cycle.
//   No new accept is taken in the same cycle as the handshake.
//  Latency: accept edge to rsp_valid = ADD_LATENCY+1 cycles. Throughput: 1 op per ADD_LATENCY+2 cycles minimum.
//  Requester may drop req_valid before it is granted; no grant is held or reserved for it.
//  rsp_ready held low: FSM stalls in RESP indefinitely; all req_ready stay 0.
//  The pointer only advances on accept. An idle cycle does not rotate priority.
// CONFIGURATION
//  FLAG_STICKY_EN defined: flag_ovf/flag_inx set on each rsp handshake when the matching rsp_* bit = 1.
//   flag_clr clears both. Simultaneous clr and set: set wins. Reset value 0.
//  FLAG_STICKY_EN undefined: flag_ovf/flag_inx tied 0; flag_clr ignored; no flag registers.
// STRUCTURE
//  Package fp_add_sched_pkg: state enum {IDLE,BUSY,RESP}, FP_W=32, localparam function for ID_W.
//  Sub-module rr_arbiter #(N): combinational req/pointer -> one-hot grant + encoded index.
//   The pointer register is held in fp_add_sched.
//  Counter width = $clog2(ADD_LATENCY+1).
// TESTING
//  1 Single op: req0 A=0x3F800000, B=0x40000000, add, L=3.
//    -> add_start 1 cycle; rsp_valid 4 cycles after accept; rsp_result=0x40400000, id=0.
//  2 All 4 valid continuously, rsp_ready=1 -> service order 0,1,2,3,0; each slot ADD_LATENCY+2 cycles apart.
//  3 Overflow: A=B=0x7F7FFFFF -> rsp_result=0x7F800000, rsp_overflow=1.
//    With FLAG_STICKY_EN, flag_ovf=1 until flag_clr.
//  4 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, req_ready all 0; release -> IDLE next cycle.
//  5 Reset asserted in BUSY cnt=1 -> outputs 0 immediately; after release req2 is granted first (pointer 0, req0/1 idle).
//  6 Priority: last grant=3; req1 and req3 valid -> req1 granted; flag_clr and set in same cycle -> flag stays 1.

Source files
------------

// File: rtl/fp_add_sched_pkg.sv
// Shared types and constants for the FP add/sub scheduler.
// State encoding, operand width and the requester-ID width helper.
package fp_add_sched_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_add_sched_if.sv
// Bundle of requester, adder-core, response and sticky-flag signals of fp_add_sched.
// master = requesters/core/consumer side, slave = the scheduler itself.
interface fp_add_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    import fp_add_sched_pkg::*;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*FP_W-1:0] req_a;
    logic [NUM_REQ*FP_W-1:0] req_b;
    logic [NUM_REQ-1:0]      req_sub;

    logic [FP_W-1:0]         add_a;
    logic [FP_W-1:0]         add_b;
    logic                    add_sub;
    logic                    add_start;
    logic [FP_W-1:0]         add_result;
    logic                    add_overflow;
    logic                    add_inexact;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [FP_W-1:0]         rsp_result;
    logic                    rsp_overflow;
    logic                    rsp_inexact;

    logic                    flag_clr;
    logic                    flag_ovf;
    logic                    flag_inx;

    modport master (
        output req_valid, req_a, req_b, req_sub,
        input  req_ready,
        input  add_a, add_b, add_sub, add_start,
        output add_result, add_overflow, add_inexact,
        input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_inexact,
        output rsp_ready, flag_clr,
        input  flag_ovf, flag_inx
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub,
        output req_ready,
        output add_a, add_b, add_sub, add_start,
        input  add_result, add_overflow, add_inexact,
        output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_inexact,
        input  rsp_ready, flag_clr,
        output flag_ovf, flag_inx
    );

endinterface

// File: rtl/fp_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping modulo N.
// Pure logic, no state; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one FP add/sub core among NUM_REQ requesters; result returned with ID.
// Optional sticky overflow/inexact flags are built when FLAG_STICKY_EN is defined.
module fp_add_sched
    import fp_add_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 3,
    parameter int ID_W        = id_width(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_add_sched_if.slave bus
);

    localparam int CNT_W = $clog2(ADD_LATENCY + 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FP_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic              sub_q, sub_d, ovf_q, ovf_d, inx_q, inx_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               rsp_hs;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        sub_d         = sub_q;
        res_d         = res_q;
        ovf_d         = ovf_q;
        inx_d         = inx_q;
        bus.req_ready = '0;
        bus.add_start = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = gnt;
                if (gnt_any) begin
                    a_d     = bus.req_a[gnt_idx*FP_W +: FP_W];
                    b_d     = bus.req_b[gnt_idx*FP_W +: FP_W];
                    sub_d   = bus.req_sub[gnt_idx];
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.add_start = (cnt_q == '0);
                cnt_d         = cnt_q + 1'b1;
                // Core result is sampled on the edge that ends the last busy cycle.
                if (cnt_q == CNT_W'(ADD_LATENCY - 1)) begin
                    res_d   = bus.add_result;
                    ovf_d   = bus.add_overflow;
                    inx_d   = bus.add_inexact;
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            inx_q   <= inx_d;
        end
    end

    assign rsp_hs           = (state_q == RESP) && bus.rsp_ready;
    assign bus.add_a        = a_q;
    assign bus.add_b        = b_q;
    assign bus.add_sub      = sub_q;
    assign bus.rsp_id       = id_q;
    assign bus.rsp_result   = res_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.rsp_inexact  = inx_q;

`ifdef FLAG_STICKY_EN
    logic flag_ovf_q, flag_ovf_d, flag_inx_q, flag_inx_d;

    // A set on the handshake beats a simultaneous clear.
    assign flag_ovf_d = (rsp_hs && ovf_q) ? 1'b1 : (bus.flag_clr ? 1'b0 : flag_ovf_q);
    assign flag_inx_d = (rsp_hs && inx_q) ? 1'b1 : (bus.flag_clr ? 1'b0 : flag_inx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_ovf_q <= 1'b0;
            flag_inx_q <= 1'b0;
        end else begin
            flag_ovf_q <= flag_ovf_d;
            flag_inx_q <= flag_inx_d;
        end
    end

    assign bus.flag_ovf = flag_ovf_q;
    assign bus.flag_inx = flag_inx_q;
`else
    logic unused_flag_in;
    assign unused_flag_in = bus.flag_clr ^ rsp_hs;
    assign bus.flag_ovf   = 1'b0;
    assign bus.flag_inx   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_sched.sv
// Randomized bench for fp_add_sched against a cycle-count transaction model plus directed scenarios.
// The adder core is a registered stand-in that returns known IEEE results for the directed operands.
module tb_fp_add_sched;
    import fp_add_sched_pkg::*;

    localparam int N = 4;
    localparam int L = 3;
`ifdef FLAG_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_add_sched_if #(.NUM_REQ(N), .ID_W(2)) bus ();

    fp_add_sched #(.NUM_REQ(N), .ADD_LATENCY(L), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] op_a [N];
    logic [31:0] op_b [N];
    logic        op_sub [N];
    logic        op_vld [N];

    // transaction model state
    bit          pend;
    int          acc_cyc, pid, m_ptr, next_free;
    logic [31:0] pa, pb;
    logic        psub;
    bit          m_fovf, m_finx;

    // what the DUT was seen doing
    int          dut_acc_id, dut_acc_cyc, start_cnt;
    int          log_id [$];
    int          log_cyc [$];
    logic [31:0] log_res [$];
    bit          log_ovf [$];

    // {overflow, inexact, result}
    function automatic logic [33:0] core_fn(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return {2'b00, 32'h4040_0000};
        if (!sub && a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) return {2'b11, 32'h7F80_0000};
        return {a[5] ^ b[9], a[7] | b[3], (sub ? a - b : a + b) ^ 32'h5A5A_0000};
    endfunction

    always @(posedge clk)
        {bus.add_overflow, bus.add_inexact, bus.add_result} <= core_fn(bus.add_a, bus.add_b, bus.add_sub);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = op_vld[i];
            bus.req_a[i*32 +: 32]    = op_a[i];
            bus.req_b[i*32 +: 32]    = op_b[i];
            bus.req_sub[i]           = op_sub[i];
        end
    endtask

    task automatic model_reset();
        pend = 0; m_ptr = 0; next_free = 0; m_fovf = 0; m_finx = 0;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        op_a[i] = a; op_b[i] = b; op_sub[i] = s; op_vld[i] = 1'b1;
    endtask

    task automatic tick();
        logic [N-1:0] exp_rdy;
        int           g;
        bit           rsp_exp, hs;
        logic [33:0]  core;
        drive();
        @(negedge clk);
        exp_rdy = '0;
        g       = -1;
        if (!pend && cyc >= next_free)
            for (int k = 0; k < N; k++)
                if (g < 0 && op_vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("add_start", 64'(bus.add_start), 64'(pend && cyc == acc_cyc + 1));
        core = core_fn(pa, pb, psub);
        if (pend && cyc > acc_cyc && cyc <= acc_cyc + L) begin
            chk("add_a", 64'(bus.add_a), 64'(pa));
            chk("add_b", 64'(bus.add_b), 64'(pb));
            chk("add_sub", 64'(bus.add_sub), 64'(psub));
        end
        rsp_exp = pend && cyc >= acc_cyc + L + 1;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(rsp_exp));
        chk("flag_ovf", 64'(bus.flag_ovf), 64'(m_fovf));
        chk("flag_inx", 64'(bus.flag_inx), 64'(m_finx));
        if (rsp_exp) begin
            chk("rsp_id", 64'(bus.rsp_id), 64'(pid));
            chk("rsp_result", 64'(bus.rsp_result), 64'(core[31:0]));
            chk("rsp_overflow", 64'(bus.rsp_overflow), 64'(core[33]));
            chk("rsp_inexact", 64'(bus.rsp_inexact), 64'(core[32]));
        end
        dut_acc_id = -1;
        for (int i = 0; i < N; i++)
            if (bus.req_ready[i] && bus.req_valid[i]) begin dut_acc_id = i; dut_acc_cyc = cyc; end
        if (bus.add_start) start_cnt++;
        if (bus.rsp_valid && bus.rsp_ready) begin
            log_id.push_back(int'(bus.rsp_id));
            log_cyc.push_back(cyc);
            log_res.push_back(bus.rsp_result);
            log_ovf.push_back(bus.rsp_overflow);
        end
        hs = rsp_exp && bus.rsp_ready;
`ifdef FLAG_STICKY_EN
        if (hs && core[33]) m_fovf = 1; else if (bus.flag_clr) m_fovf = 0;
        if (hs && core[32]) m_finx = 1; else if (bus.flag_clr) m_finx = 0;
`endif
        if (hs) begin pend = 0; next_free = cyc + 1; end
        if (g >= 0) begin
            pend = 1; acc_cyc = cyc; pid = g; m_ptr = (g + 1) % N;
            pa = op_a[g]; pb = op_b[g]; psub = op_sub[g];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_rsp(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = bus.rsp_valid;
        end
        chk(tag, 64'(seen), 64'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"}, 64'(bus.req_ready), 64'(0));
        chk({tag, "_rspv"}, 64'(bus.rsp_valid), 64'(0));
        chk({tag, "_start"}, 64'(bus.add_start), 64'(0));
        chk({tag, "_adda"}, 64'(bus.add_a), 64'(0));
        chk({tag, "_addb"}, 64'(bus.add_b), 64'(0));
        chk({tag, "_res"}, 64'(bus.rsp_result), 64'(0));
        chk({tag, "_fovf"}, 64'(bus.flag_ovf), 64'(0));
    endtask

    logic [31:0] hold_res;
    int          hold_id;

    initial begin
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; op_sub[i] = 0; op_vld[i] = 0; end
        bus.rsp_ready = 1'b1;
        bus.flag_clr  = 1'b0;
        drive();
        model_reset();
        start_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // all four requesting continuously: strict rotation from pointer 0
        for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, 1'(i & 1));
        for (int i = 0; i < 60 && log_id.size() < 5; i++) tick();
        for (int i = 0; i < N; i++) op_vld[i] = 0;
        chk("rot_count", 64'(log_id.size()), 64'(5));
        for (int k = 0; k < 5 && k < log_id.size(); k++) begin
            chk("rot_order", 64'(log_id[k]), 64'(k % N));
            if (k > 0) chk("rot_spacing", 64'(log_cyc[k] - log_cyc[k-1]), 64'(L + 2));
        end
        repeat (4) tick();
        log_id.delete(); log_cyc.delete(); log_res.delete(); log_ovf.delete();

        // single op: 1.0 + 2.0
        start_cnt = 0;
        set_op(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        tick();
        op_vld[0] = 0;
        for (int i = 0; i < 20 && log_id.size() == 0; i++) tick();
        chk("single_seen", 64'(log_id.size()), 64'(1));
        if (log_id.size() > 0) begin
            chk("single_id", 64'(log_id[0]), 64'(0));
            chk("single_res", 64'(log_res[0]), 64'(32'h4040_0000));
            chk("single_lat", 64'(log_cyc[0] - dut_acc_cyc), 64'(L + 1));
        end
        chk("single_starts", 64'(start_cnt), 64'(1));
        log_id.delete(); log_cyc.delete(); log_res.delete(); log_ovf.delete();

        // overflow on requester 1, then sticky flag until cleared
        set_op(1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0);
        tick();
        op_vld[1] = 0;
        for (int i = 0; i < 20 && log_id.size() == 0; i++) tick();
        chk("ovf_seen", 64'(log_id.size()), 64'(1));
        if (log_id.size() > 0) begin
            chk("ovf_res", 64'(log_res[0]), 64'(32'h7F80_0000));
            chk("ovf_bit", 64'(log_ovf[0]), 64'(1));
        end
        repeat (3) tick();
        chk("ovf_sticky", 64'(bus.flag_ovf), 64'(STICKY));
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        chk("ovf_cleared", 64'(bus.flag_ovf), 64'(0));

        // backpressure: req2 served, req3 waiting, response held for 10 cycles
        bus.rsp_ready = 1'b0;
        set_op(2, 32'h1234_5678, 32'h0BAD_F00D, 1'b1);
        set_op(3, 32'h4242_4242, 32'h0101_0101, 1'b0);
        tick();
        op_vld[2] = 0;
        wait_rsp("bp_rsp_timeout");
        hold_res = bus.rsp_result;
        hold_id  = int'(bus.rsp_id);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_res_stable", 64'(bus.rsp_result), 64'(hold_res));
            chk("bp_id_stable", 64'(bus.rsp_id), 64'(hold_id));
            chk("bp_rdy_zero", 64'(bus.req_ready), 64'(0));
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_release", 64'(bus.req_ready), 64'(4'b1000));
        tick();
        op_vld[3] = 0;
        repeat (8) tick();

        // reset in BUSY with counter at 1; pointer must restart at 0
        set_op(2, 32'h0000_00FF, 32'h0000_0F00, 1'b0);
        tick();
        op_vld[2] = 0;
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_op(2, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        set_op(3, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0);
        drive();
        #1;
        chk("rst_ptr", 64'(bus.req_ready), 64'(4'b0100));
        tick();
        op_vld[2] = 0;
        // req2 completes, then req3 (the overflow op) is taken; last grant becomes 3
        for (int i = 0; i < 40 && dut_acc_id != 3; i++) tick();
        chk("g3_taken", 64'(dut_acc_id), 64'(3));
        set_op(1, 32'h4000_0000, 32'h4000_0000, 1'b1);
        set_op(3, 32'h3333_3333, 32'h1111_1111, 1'b0);
        wait_rsp("prio_rsp_timeout");
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        chk("clr_vs_set", 64'(bus.flag_ovf), 64'(STICKY));
        chk("prio_1_over_3", 64'(bus.req_ready), 64'(4'b0010));
        repeat (20) tick();
        for (int i = 0; i < N; i++) op_vld[i] = 0;
        repeat (8) tick();

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.flag_clr  = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                if (!op_vld[i] && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 7) == 0) set_op(i, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0);
                    else set_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
                end else if (op_vld[i] && $urandom_range(0, 19) == 0) begin
                    op_vld[i] = 0;
                end
            end
            tick();
            if (dut_acc_id >= 0) op_vld[dut_acc_id] = 0;
        end
        bus.rsp_ready = 1'b1;
        bus.flag_clr  = 1'b0;
        for (int i = 0; i < N; i++) op_vld[i] = 0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
